// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared types and constants for the data-memory arbiter slice.
// Provides the store-size encodings, the bus owner state enum and the
// bundle type used to carry one memory request (we/addr/wdata/bytes).
package dmem_arbiter_pkg;

   localparam int DATA_W = 32;

   // Store-size encodings as driven on the *_bytes buses
   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_BYTE = 2'd2;

   typedef enum logic {
      PIPE_OWN = 1'b0,
      DMA_OWN  = 1'b1
   } owner_t;

   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [1:0]        bytes;
   } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the three sides of the arbiter: the pipeline Memory stage
// (p_*, StallM), the DMA/boot-loader master (d_*), the data memory (m_*)
// and the dma_owner status flag.
//   slave  : the arbiter's view (requests in, memory drive and responses out)
//   master : the surrounding system's view (pipeline, DMA and memory)
interface dmem_arbiter_if #(parameter int DATA_W = dmem_arbiter_pkg::DATA_W);

   logic              p_req;
   logic              p_we;
   logic [DATA_W-1:0] p_addr;
   logic [DATA_W-1:0] p_wdata;
   logic [1:0]        p_bytes;
   logic [DATA_W-1:0] p_rdata;
   logic              StallM;

   logic              d_valid;
   logic              d_we;
   logic [DATA_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [1:0]        d_bytes;
   logic              d_last;
   logic              d_ready;
   logic [DATA_W-1:0] d_rdata;
   logic              d_rvalid;

   logic [DATA_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_we;
   logic [1:0]        m_bytes;
   logic [DATA_W-1:0] m_rdata;

   logic              dma_owner;

   modport slave (
      input  p_req, p_we, p_addr, p_wdata, p_bytes,
      output p_rdata, StallM,
      input  d_valid, d_we, d_addr, d_wdata, d_bytes, d_last,
      output d_ready, d_rdata, d_rvalid,
      output m_addr, m_wdata, m_we, m_bytes,
      input  m_rdata,
      output dma_owner
   );

   modport master (
      output p_req, p_we, p_addr, p_wdata, p_bytes,
      input  p_rdata, StallM,
      output d_valid, d_we, d_addr, d_wdata, d_bytes, d_last,
      input  d_ready, d_rdata, d_rvalid,
      input  m_addr, m_wdata, m_we, m_bytes,
      output m_rdata,
      input  dma_owner
   );

endinterface

// File: rtl/dmem_port_mux.sv
// dmem_port_mux
// Selects one of two request bundles onto the memory port.
//   sel    : 0 = pipeline bundle, 1 = DMA bundle
//   weEn   : write qualifier; the chosen write enable only reaches memory
//            when this is high
//   pReq   : pipeline request bundle
//   dReq   : DMA request bundle
//   mReq   : bundle driven to the memory
module dmem_port_mux
   import dmem_arbiter_pkg::*;
(
   input  logic     sel,
   input  logic     weEn,
   input  mem_req_t pReq,
   input  mem_req_t dReq,
   output mem_req_t mReq
);

   mem_req_t chosen;

   // Address/data/size follow the selected requester unconditionally so the
   // memory always sees a defined address; only the write strobe is gated.
   always_comb begin
      chosen   = sel ? dReq : pReq;
      mReq     = chosen;
      mReq.we  = weEn & chosen.we;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the pipeline Memory stage and a
// DMA/boot-loader master. The pipeline wins by default; the DMA uses idle
// slots, and after STARVE_LIMIT consecutive blocked cycles it is granted a
// forced burst of up to MAX_BURST beats while the pipeline is stalled.
// Ports:
//   CLK  : system clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : dmem_arbiter_if.slave carrying pipeline, DMA, memory and status
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_BURST    = 8
) (
   input  logic           CLK,
   input  logic           RST,
   dmem_arbiter_if.slave  bus
);

   localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);
   localparam logic [3:0] BURST_LAST  = 4'(MAX_BURST - 1);

   owner_t            state;
   owner_t            nextState;
   logic [3:0]        starveCnt;
   logic [3:0]        nextStarve;
   logic [3:0]        beatCnt;
   logic [3:0]        nextBeat;
   logic              selDma;
   logic              weEn;
   logic              dReady;
   logic              stall;
   logic [DATA_W-1:0] dRdataQ;
   logic              dRvalidQ;
   mem_req_t          pBundle;
   mem_req_t          dBundle;
   mem_req_t          mBundle;

   assign pBundle = '{we: bus.p_we, addr: bus.p_addr, wdata: bus.p_wdata, bytes: bus.p_bytes};
   assign dBundle = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata, bytes: bus.d_bytes};

   dmem_port_mux portMux (
      .sel  (selDma),
      .weEn (weEn),
      .pReq (pBundle),
      .dReq (dBundle),
      .mReq (mBundle)
   );

   // Next-state and port-control logic. In PIPE_OWN the pipeline always wins
   // and the DMA only slips into idle slots; a DMA beat that keeps losing
   // builds up starveCnt until it earns a forced burst. In DMA_OWN the DMA
   // owns the port and the burst ends on d_last, on the beat cap, or on the
   // first bubble. Reset overrides every strobe so the beat presented during
   // the reset cycle is neither written nor acknowledged.
   always_comb begin
      nextState  = state;
      nextStarve = starveCnt;
      nextBeat   = beatCnt;
      selDma     = 1'b0;
      weEn       = 1'b0;
      dReady     = 1'b0;
      stall      = 1'b0;
      case (state)
         PIPE_OWN: begin
            if (bus.p_req) begin
               weEn = 1'b1;
            end else if (bus.d_valid) begin
               selDma = 1'b1;
               weEn   = 1'b1;
               dReady = 1'b1;
            end
            if (bus.p_req && bus.d_valid) begin
               if (starveCnt == STARVE_LAST) begin
                  nextState  = DMA_OWN;
                  nextStarve = 4'd0;
                  nextBeat   = 4'd0;
               end else begin
                  nextStarve = starveCnt + 4'd1;
               end
            end else begin
               nextStarve = 4'd0;
            end
         end
         DMA_OWN: begin
            selDma = 1'b1;
            weEn   = bus.d_valid;
            dReady = bus.d_valid;
            stall  = bus.p_req;
            if (bus.d_valid) begin
               nextBeat = beatCnt + 4'd1;
               if (bus.d_last || (beatCnt == BURST_LAST)) begin
                  nextState = PIPE_OWN;
               end
            end else begin
               nextState = PIPE_OWN;
            end
         end
         default: begin
            nextState = PIPE_OWN;
         end
      endcase
      if (RST) begin
         weEn   = 1'b0;
         dReady = 1'b0;
         stall  = 1'b0;
      end
   end

   // State, counters and the registered DMA read-return path. A DMA read is
   // captured from the combinational memory output on the accepting edge and
   // presented with a one-cycle d_rvalid pulse; the data is held afterwards.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= PIPE_OWN;
         starveCnt <= 4'd0;
         beatCnt   <= 4'd0;
         dRvalidQ  <= 1'b0;
         dRdataQ   <= '0;
      end else begin
         state     <= nextState;
         starveCnt <= nextStarve;
         beatCnt   <= nextBeat;
         dRvalidQ  <= dReady & ~bus.d_we;
         if (dReady && !bus.d_we) begin
            dRdataQ <= bus.m_rdata;
         end
      end
   end

   assign bus.m_addr    = mBundle.addr;
   assign bus.m_wdata   = mBundle.wdata;
   assign bus.m_we      = mBundle.we;
   assign bus.m_bytes   = mBundle.bytes;
   assign bus.p_rdata   = bus.m_rdata;
   assign bus.StallM    = stall;
   assign bus.d_ready   = dReady;
   assign bus.d_rdata   = dRdataQ;
   assign bus.d_rvalid  = dRvalidQ;
   assign bus.dma_owner = (state == DMA_OWN);

endmodule
